// File: rtl/hs32_regwrite_checker_pkg.sv
// Shared definitions for the hs32 register-file write checker:
// FSM state encoding and failure cause codes.
package hs32_regwrite_checker_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StPass = 2'd2,
    StFail = 2'd3
  } chk_state_e;

  typedef enum logic [2:0] {
    FcNone    = 3'd0,
    FcAdr     = 3'd1,
    FcData    = 3'd2,
    FcOverrun = 3'd3,
    FcTimeout = 3'd4,
    FcFault   = 3'd5,
    FcBadcfg  = 3'd6
  } fail_code_e;

endpackage

// File: rtl/hs32_chk_table.sv
// Expected-write table: DEPTH x (address, data) registers, synchronous write,
// combinational read. Contents are deliberately not reset.
module hs32_chk_table #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [SW-1:0] wr_idx,
  input  logic [AW-1:0] wr_adr,
  input  logic [DW-1:0] wr_din,
  input  logic [SW-1:0] rd_idx,
  output logic [AW-1:0] rd_adr,
  output logic [DW-1:0] rd_din
);

  logic [AW-1:0] adr_mem [DEPTH];
  logic [DW-1:0] din_mem [DEPTH];

  // Indices at or above DEPTH match no entry, so such writes fall away.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (we && (wr_idx == SW'(i))) begin
        adr_mem[i] <= wr_adr;
        din_mem[i] <= wr_din;
      end
    end
  end

  always_comb begin
    rd_adr = '0;
    rd_din = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (rd_idx == SW'(i)) begin
        rd_adr = adr_mem[i];
        rd_din = din_mem[i];
      end
    end
  end

endmodule

// File: rtl/hs32_regwrite_checker.sv
// Checks hs32 register-file writes against a loadable expectation table in
// strict (exact sequence) or weak (in-order subsequence) mode.
module hs32_regwrite_checker
  import hs32_regwrite_checker_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TMO_W = 16,
  localparam int unsigned SW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tbl_we,
  input  logic [SW-1:0]    tbl_idx,
  input  logic [AW-1:0]    tbl_adr,
  input  logic [DW-1:0]    tbl_din,
  input  logic [SW-1:0]    exp_count,
  input  logic             mode_strict,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic             arm,
  input  logic             clear,
  input  logic             rf_we,
  input  logic [AW-1:0]    rf_wadr,
  input  logic [DW-1:0]    rf_din,
  input  logic             fault,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [2:0]       fail_code,
  output logic [SW-1:0]    step,
  output logic [AW-1:0]    fail_adr,
  output logic [DW-1:0]    fail_din
);

  chk_state_e       state_q, state_d;
  fail_code_e       code_q, code_d;
  logic [SW-1:0]    step_q, step_d;
  logic [SW-1:0]    count_q, count_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] limit_q, limit_d;
  logic             strict_q, strict_d;
  logic [AW-1:0]    fadr_q, fadr_d;
  logic [DW-1:0]    fdin_q, fdin_d;

  logic [AW-1:0] ent_adr;
  logic [DW-1:0] ent_din;
  logic          adr_hit, din_hit, wr_match, tmo_hit;
  logic [SW-1:0] step_inc;

  hs32_chk_table #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_table (
    .clk    (clk),
    .we     (tbl_we && (state_q != StRun)),
    .wr_idx (tbl_idx),
    .wr_adr (tbl_adr),
    .wr_din (tbl_din),
    .rd_idx (step_q),
    .rd_adr (ent_adr),
    .rd_din (ent_din)
  );

  assign adr_hit  = (rf_wadr == ent_adr);
  assign din_hit  = (rf_din == ent_din);
  assign wr_match = rf_we && adr_hit && din_hit;
  assign step_inc = step_q + SW'(1);
  assign tmo_hit  = (limit_q != '0) && (cnt_q == limit_q - TMO_W'(1));

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    step_d   = step_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    limit_d  = limit_q;
    strict_d = strict_q;
    fadr_d   = fadr_q;
    fdin_d   = fdin_q;
    if (clear) begin
      state_d = StIdle;
      code_d  = FcNone;
      step_d  = '0;
      fadr_d  = '0;
      fdin_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            count_d  = exp_count;
            strict_d = mode_strict;
            limit_d  = tmo_limit;
            step_d   = '0;
            cnt_d    = '0;
            if (exp_count == '0) begin
              state_d = StPass;
            end else if (exp_count > SW'(DEPTH)) begin
              state_d = StFail;
              code_d  = FcBadcfg;
            end else begin
              state_d = StRun;
            end
          end
        end
        StRun: begin
          cnt_d = cnt_q + TMO_W'(1);
          if (fault) begin
            state_d = StFail;
            code_d  = FcFault;
          end else if (rf_we && strict_q && !adr_hit) begin
            state_d = StFail;
            code_d  = FcAdr;
            fadr_d  = rf_wadr;
            fdin_d  = rf_din;
          end else if (rf_we && strict_q && !din_hit) begin
            state_d = StFail;
            code_d  = FcData;
            fadr_d  = rf_wadr;
            fdin_d  = rf_din;
          end else if (wr_match && (step_inc == count_q)) begin
            // Completion beats a timeout landing on the same cycle.
            step_d  = step_inc;
            state_d = StPass;
          end else if (tmo_hit) begin
            state_d = StFail;
            code_d  = FcTimeout;
          end else if (wr_match) begin
            step_d = step_inc;
          end
        end
        StPass: begin
          if (fault) begin
            state_d = StFail;
            code_d  = FcFault;
          end else if (rf_we && strict_q) begin
            state_d = StFail;
            code_d  = FcOverrun;
            fadr_d  = rf_wadr;
            fdin_d  = rf_din;
          end
        end
        StFail: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      code_q   <= FcNone;
      step_q   <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      limit_q  <= '0;
      strict_q <= 1'b0;
      fadr_q   <= '0;
      fdin_q   <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      step_q   <= step_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      limit_q  <= limit_d;
      strict_q <= strict_d;
      fadr_q   <= fadr_d;
      fdin_q   <= fdin_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign pass      = (state_q == StPass);
  assign fail      = (state_q == StFail);
  assign fail_code = code_q;
  assign step      = step_q;
  assign fail_adr  = fadr_q;
  assign fail_din  = fdin_q;

endmodule
